// File: rtl/shift_sequencer.sv
// Sequencing controller that realises an 8-bit shift job as +/-1 and +/-2 steps through tranShifter.
// Optional rotate mode is enabled with the SHIFT_SEQ_ROTATE_EN macro (adds input in_rot).

module tranShifter (
    input  logic [0:7] Ip,
    input  logic [0:4] shift_mag,
    output logic [0:7] Op
);

    // Index 0 is the MSB, so "left" (toward index 0) is a numeric << and "right" is a numeric >>.
    always_comb begin
        Op = Ip;
        if (shift_mag[0]) begin
            Op = Ip >> 2;
        end else if (shift_mag[1]) begin
            Op = Ip >> 1;
        end else if (shift_mag[3]) begin
            Op = Ip << 1;
        end else if (shift_mag[4]) begin
            Op = Ip << 2;
        end
    end

endmodule

module shift_sequencer #(
    parameter int DATA_W    = 8,
    parameter int AMT_W     = 3,
    parameter int USE_STEP2 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DATA_W-1] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic              in_rot,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_data,
    output logic              busy
);

    generate
        if (DATA_W != 8) begin : g_width_check
            $error("shift_sequencer: DATA_W must be 8 to match tranShifter");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [0:DATA_W-1]   acc_q, acc_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic                dir_q, dir_d;
    logic [1:0]          step;
    logic [0:4]          shift_mag;
    logic [0:DATA_W-1]   shift_out;
    logic [0:DATA_W-1]   wrap_bits;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic                rot_q, rot_d;
`endif

    tranShifter u_shifter (
        .Ip        (acc_q),
        .shift_mag (shift_mag),
        .Op        (shift_out)
    );

    always_comb begin
        step      = 2'd0;
        shift_mag = 5'b00100;
        if (state_q == BUSY) begin
            if ((USE_STEP2 != 0) && (rem_q >= AMT_W'(2))) begin
                step = 2'd2;
            end else if (rem_q != '0) begin
                step = 2'd1;
            end
        end
        case ({dir_q, step})
            3'b0_01: shift_mag = 5'b00010;
            3'b0_10: shift_mag = 5'b00001;
            3'b1_01: shift_mag = 5'b01000;
            3'b1_10: shift_mag = 5'b10000;
            default: shift_mag = 5'b00100;
        endcase
    end

    // Bits pushed off one end are recovered here and ORed into the zero-filled end.
    always_comb begin
        wrap_bits = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot_q && (step != 2'd0)) begin
            if (dir_q) begin
                wrap_bits = acc_q << (DATA_W - int'(step));
            end else begin
                wrap_bits = acc_q >> (DATA_W - int'(step));
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = in_amt;
                    dir_d   = in_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d   = in_rot;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = shift_out | wrap_bits;
                rem_d = rem_q - AMT_W'(step);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Result is gated so an in-flight accumulator value never appears on out_data.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; a second instance covers USE_STEP2 = 0.
// Rotate-mode steps are compiled in only when SHIFT_SEQ_ROTATE_EN is defined.

module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_data;
    logic       in_dir;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_data;
    logic       busy;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic       in_rot;
    logic       in_rot_b;
`endif

    logic       rst_n_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic [0:7] in_data_b;
    logic       in_dir_b;
    logic [2:0] in_amt_b;
    logic       out_valid_b;
    logic       out_ready_b;
    logic [0:7] out_data_b;
    logic       busy_b;

    int assert_count = 0;
    int fail_count   = 0;

    int          busy_cycles;
    logic [39:0] codes;
    logic [7:0]  result;
    logic        done_seen;
    int          valid_seen;

    always #5 clk = ~clk;

    shift_sequencer #(.DATA_W(8), .AMT_W(3), .USE_STEP2(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
`ifdef SHIFT_SEQ_ROTATE_EN
        .in_rot    (in_rot),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    shift_sequencer #(.DATA_W(8), .AMT_W(3), .USE_STEP2(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_dir    (in_dir_b),
        .in_amt    (in_amt_b),
`ifdef SHIFT_SEQ_ROTATE_EN
        .in_rot    (in_rot_b),
`endif
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .busy      (busy_b)
    );

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one job from IDLE and follows it until out_valid, logging each BUSY-cycle shifter code.
    task automatic applyStimulus(input logic [7:0] data, input logic dir, input logic [2:0] amt,
                                 output int n_busy, output logic [39:0] seen_codes,
                                 output logic [7:0] res, output logic finished);
        in_data  = data;
        in_dir   = dir;
        in_amt   = amt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        n_busy     = 0;
        seen_codes = '0;
        finished   = 1'b0;
        for (int i = 0; i < 20 && !finished; i++) begin
            if (out_valid) begin
                finished = 1'b1;
            end else begin
                if (busy) begin
                    n_busy++;
                    seen_codes = {seen_codes[34:0], dut.shift_mag};
                end
                @(negedge clk);
            end
        end
        res = out_data;
    endtask

    task automatic releaseResult;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_dir      = 1'b0;
        in_amt      = '0;
        out_ready   = 1'b0;
        rst_n_b     = 1'b1;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        in_dir_b    = 1'b0;
        in_amt_b    = '0;
        out_ready_b = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
        in_rot      = 1'b0;
        in_rot_b    = 1'b0;
`endif

        $display("[TB] reset then idle");
        repeat (2) @(negedge clk);
        #2;
        rst_n   = 1'b0;
        rst_n_b = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);
        checkOutput("idle_shift_mag", dut.shift_mag, 5'b00100);
        checkOutput("idle_in_ready", in_ready, 1'b1);

        $display("[TB] left by 3");
        applyStimulus(8'hAD, 1'b0, 3'd3, busy_cycles, codes, result, done_seen);
        checkOutput("l3_done", done_seen, 1'b1);
        checkOutput("l3_busy_cycles", busy_cycles, 2);
        checkOutput("l3_codes", codes, 40'h22);
        checkOutput("l3_data", result, 8'h68);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("l3_hold_valid", out_valid, 1'b1);
            checkOutput("l3_hold_data", out_data, 8'h68);
        end
        releaseResult();
        checkOutput("l3_valid_cleared", out_valid, 1'b0);
        checkOutput("l3_ready_back", in_ready, 1'b1);

        $display("[TB] right by 2");
        applyStimulus(8'hAD, 1'b1, 3'd2, busy_cycles, codes, result, done_seen);
        checkOutput("r2_done", done_seen, 1'b1);
        checkOutput("r2_busy_cycles", busy_cycles, 1);
        checkOutput("r2_codes", codes, 40'h10);
        checkOutput("r2_data", result, 8'h2B);
        releaseResult();

        $display("[TB] amount 0 and amount 7");
        applyStimulus(8'h55, 1'b0, 3'd0, busy_cycles, codes, result, done_seen);
        checkOutput("a0_done", done_seen, 1'b1);
        checkOutput("a0_busy_cycles", busy_cycles, 1);
        checkOutput("a0_codes", codes, 40'h04);
        checkOutput("a0_data", result, 8'h55);
        releaseResult();
        applyStimulus(8'h81, 1'b0, 3'd7, busy_cycles, codes, result, done_seen);
        checkOutput("a7_done", done_seen, 1'b1);
        checkOutput("a7_busy_cycles", busy_cycles, 4);
        checkOutput("a7_codes", codes, 40'h08422);
        checkOutput("a7_data", result, 8'h80);
        releaseResult();

        $display("[TB] in_valid held through BUSY and DONE");
        in_data  = 8'hF0;
        in_dir   = 1'b1;
        in_amt   = 3'd1;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("hold_busy", busy, 1'b1);
        checkOutput("hold_ready_busy", in_ready, 1'b0);
        in_data = 8'hFF;
        @(negedge clk);
        checkOutput("hold_valid", out_valid, 1'b1);
        checkOutput("hold_ready_done", in_ready, 1'b0);
        checkOutput("hold_sampled_data", out_data, 8'h78);
        @(negedge clk);
        checkOutput("hold_no_reaccept", busy, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("hold_idle_valid", out_valid, 1'b0);
        checkOutput("hold_idle_ready", in_ready, 1'b1);
        checkOutput("hold_idle_busy", busy, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("hold_second_accept", busy, 1'b1);
        @(negedge clk);
        checkOutput("hold_second_valid", out_valid, 1'b1);
        checkOutput("hold_second_data", out_data, 8'h7F);
        releaseResult();

        $display("[TB] reset during amt-5 job");
        in_data  = 8'h3C;
        in_dir   = 1'b0;
        in_amt   = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rj_busy1", busy, 1'b1);
        @(negedge clk);
        checkOutput("rj_busy2", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rj_busy_cleared", busy, 1'b0);
        checkOutput("rj_in_ready", in_ready, 1'b1);
        checkOutput("rj_out_valid", out_valid, 1'b0);
        checkOutput("rj_out_data", out_data, 8'h00);
        @(negedge clk);
        rst_n      = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) valid_seen++;
        end
        checkOutput("rj_no_partial_result", valid_seen, 0);
        applyStimulus(8'h0F, 1'b0, 3'd5, busy_cycles, codes, result, done_seen);
        checkOutput("rj_next_done", done_seen, 1'b1);
        checkOutput("rj_next_busy_cycles", busy_cycles, 3);
        checkOutput("rj_next_codes", codes, 40'h0422);
        checkOutput("rj_next_data", result, 8'hE0);
        releaseResult();

`ifdef SHIFT_SEQ_ROTATE_EN
        $display("[TB] rotate mode");
        in_rot = 1'b1;
        applyStimulus(8'hAD, 1'b0, 3'd3, busy_cycles, codes, result, done_seen);
        checkOutput("rot_l3_done", done_seen, 1'b1);
        checkOutput("rot_l3_busy_cycles", busy_cycles, 2);
        checkOutput("rot_l3_data", result, 8'h6D);
        releaseResult();
        applyStimulus(8'hAD, 1'b1, 3'd3, busy_cycles, codes, result, done_seen);
        checkOutput("rot_r3_data", result, 8'hB5);
        releaseResult();
        in_rot = 1'b0;
        applyStimulus(8'hAD, 1'b0, 3'd3, busy_cycles, codes, result, done_seen);
        checkOutput("norot_l3_data", result, 8'h68);
        releaseResult();
`endif

        $display("[TB] single-step instance, left by 7");
        in_data_b  = 8'h81;
        in_dir_b   = 1'b0;
        in_amt_b   = 3'd7;
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b  = 1'b0;
        busy_cycles = 0;
        done_seen   = 1'b0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (out_valid_b) begin
                done_seen = 1'b1;
            end else begin
                if (busy_b) busy_cycles++;
                @(negedge clk);
            end
        end
        checkOutput("s1_a7_done", done_seen, 1'b1);
        checkOutput("s1_a7_busy_cycles", busy_cycles, 7);
        checkOutput("s1_a7_data", out_data_b, 8'h80);
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
        checkOutput("s1_valid_cleared", out_valid_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
